load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 32 +++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   funct3_t       : RV32I load/store width codes
//   state_t        : control FSM states
//   READ_LATENCY_DEFAULT : cycles from vaddr presented to q valid
//   access_faults(): decides whether a request must be rejected before
//                    touching the mmu (illegal width code or misalignment)
package lsu_pkg;

    localparam int READ_LATENCY_DEFAULT = 3;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Unsigned widths only exist for loads, so BU/HU with a store is illegal.
    function automatic logic access_faults(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] byte_off);
        logic fault;
        case (f3)
            F3_B:         fault = 1'b0;
            F3_H:         fault = byte_off[0];
            F3_W:         fault = (byte_off != 2'b00);
            F3_BU, F3_HU: fault = is_store;
            default:      fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational extract/extend of a load result.
// Ports:
//   q        in  32  raw word returned by the mmu
//   addr     in  2   byte offset of the load within the word
//   funct3   in  3   width code (B, H, W, BU, HU)
//   loadData out 32  right-aligned, sign/zero-extended result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] q,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] loadData
);

    logic [31:0] shifted;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = q >> {addr, 3'b000};

    always_comb begin
        loadData = shifted;
        case (funct3)
            F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   loadData = {24'b0, shifted[7:0]};
            F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   loadData = {16'b0, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding RV32I load/store unit between the
// CPU and an mmu with a fixed read latency.
// CPU side:
//   reqValid/reqReady  request handshake (ready only in IDLE)
//   isStore, funct3, addr, storeData  request fields
//   respValid          one-cycle completion pulse
//   loadData           extended load result (valid with respValid)
//   accessFault        misaligned / illegal width (valid with respValid)
// MMU side:
//   vaddr, data, byteena, memWE  outputs, zero outside ACCESS/WAIT
//   q                            read data, valid READ_LATENCY cycles
//                                after vaddr is first presented
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
    input  logic        clock,
    input  logic        RST,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        respValid,
    output logic [31:0] loadData,
    output logic        accessFault,
    output logic [31:0] vaddr,
    output logic [31:0] data,
    output logic [3:0]  byteena,
    output logic        memWE,
    input  logic [31:0] q
);

    localparam int CNT_W = ($clog2(READ_LATENCY + 1) < 2) ? 2 : $clog2(READ_LATENCY + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               fault_reg, fault_next;
    logic [31:0]        load_data_reg, load_data_next;

    // Request fields captured on acceptance.
    logic               is_store_reg;
    logic [2:0]         funct3_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        store_data_reg;
    logic [3:0]         byteena_reg;

    logic               accept;
    logic               req_fault;
    logic [3:0]         req_byteena;
    logic [31:0]        aligned_data;

    assign accept    = reqValid && (state_reg == ST_IDLE);
    assign req_fault = access_faults(isStore, funct3, addr[1:0]);

    always_comb begin
        req_byteena = 4'b1111;
        case (funct3)
            F3_B:    req_byteena = 4'b0001 << addr[1:0];
            F3_H:    req_byteena = 4'b0011 << addr[1:0];
            default: req_byteena = 4'b1111;
        endcase
    end

    lsu_load_align u_align (
        .q        (q),
        .addr     (addr_reg[1:0]),
        .funct3   (funct3_reg),
        .loadData (aligned_data)
    );

    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            fault_reg      <= 1'b0;
            load_data_reg  <= '0;
            is_store_reg   <= 1'b0;
            funct3_reg     <= '0;
            addr_reg       <= '0;
            store_data_reg <= '0;
            byteena_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            fault_reg     <= fault_next;
            load_data_reg <= load_data_next;
            if (accept) begin
                is_store_reg   <= isStore;
                funct3_reg     <= funct3;
                addr_reg       <= addr;
                store_data_reg <= storeData << {addr[1:0], 3'b000};
                byteena_reg    <= req_byteena;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        fault_next     = fault_reg;
        load_data_next = load_data_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next       = '0;
                fault_next     = 1'b0;
                load_data_next = '0;
                if (reqValid) begin
                    if (req_fault) begin
                        state_next = ST_RESP;
                        fault_next = 1'b1;
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (is_store_reg) begin
                    state_next = ST_RESP;
                end else begin
                    // vaddr has now been on the bus for one cycle.
                    state_next = ST_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_reg == CNT_W'(READ_LATENCY)) begin
                    state_next     = ST_RESP;
                    cnt_next       = '0;
                    load_data_next = aligned_data;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_next     = ST_IDLE;
                fault_next     = 1'b0;
                load_data_next = '0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so reset clears them
    // immediately and they are zero outside the mmu-facing states.
    assign reqReady    = (state_reg == ST_IDLE);
    assign respValid   = (state_reg == ST_RESP);
    assign accessFault = fault_reg;
    assign loadData    = load_data_reg;
    assign vaddr       = ((state_reg == ST_ACCESS) || (state_reg == ST_WAIT)) ? addr_reg : 32'd0;
    assign memWE       = (state_reg == ST_ACCESS) && is_store_reg;
    assign byteena     = memWE ? byteena_reg : 4'b0000;
    assign data        = memWE ? store_data_reg : 32'd0;

endmodule
